// File: rtl/wb_gcd_unit.sv
`timescale 1ns/1ps
// Wishbone-B4 classic slave with a subtractive-Euclid GCD engine, sticky done/pending
// status, a maskable level interrupt and a busy flag.
//   state | meaning
//   IDLE  | waiting for a START write; result/status hold
//   CALC  | one subtract-or-swap step per cycle until b reaches zero
module wb_gcd_unit #(
    parameter int          WIDTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o,
    output logic        busy_o
);
    typedef enum logic {IDLE, CALC} state_t;

    localparam logic [9:0] OFF_OPA    = 10'h000;
    localparam logic [9:0] OFF_OPB    = 10'h001;
    localparam logic [9:0] OFF_CTRL   = 10'h002;
    localparam logic [9:0] OFF_STATUS = 10'h003;
    localparam logic [9:0] OFF_RESULT = 10'h004;
    localparam logic [9:0] OFF_CYCLES = 10'h005;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_opa, r_opb, r_a, r_b, r_result;
    logic [31:0]        r_cycles, r_dat;
    logic               r_ack, r_irq_en, r_done, r_pending, r_irq;

    logic               w_hit, w_req, w_wr, w_ctrl_wr, w_start, w_clr, w_calc_end;
    logic [9:0]         w_off;
    logic [31:0]        w_bmask, w_opa_wr, w_opb_wr, w_rdata;
    logic [1:0]         w_unused_adr;

    assign w_hit        = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign w_req        = wbs_stb_i & wbs_cyc_i & w_hit & ~r_ack;
    assign w_wr         = w_req & wbs_we_i;
    assign w_off        = wbs_adr_i[11:2];
    assign w_unused_adr = wbs_adr_i[1:0];
    assign w_ctrl_wr    = w_wr & (w_off == OFF_CTRL) & wbs_sel_i[0];
    assign w_start      = w_ctrl_wr & wbs_dat_i[0] & (r_state == IDLE);
    assign w_clr        = w_ctrl_wr & wbs_dat_i[2];
    assign w_calc_end   = (r_state == CALC) && (r_b == '0);

    assign w_bmask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign w_opa_wr = (32'(r_opa) & ~w_bmask) | (wbs_dat_i & w_bmask);
    assign w_opb_wr = (32'(r_opb) & ~w_bmask) | (wbs_dat_i & w_bmask);

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_OPA:    w_rdata = 32'(r_opa);
            OFF_OPB:    w_rdata = 32'(r_opb);
            OFF_CTRL:   w_rdata = {30'b0, r_irq_en, 1'b0};
            OFF_STATUS: w_rdata = {29'b0, r_pending, r_done, (r_state == CALC)};
            OFF_RESULT: w_rdata = 32'(r_result);
            OFF_CYCLES: w_rdata = r_cycles;
            default:    w_rdata = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = CALC;
            CALC:    if (w_calc_end) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Bus side: one wait-state ack, data only valid during the ack cycle
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_irq_en <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req & ~wbs_we_i) ? w_rdata : 32'h0;
            if (w_wr && w_off == OFF_OPA) r_opa <= w_opa_wr[WIDTH-1:0];
            if (w_wr && w_off == OFF_OPB) r_opb <= w_opb_wr[WIDTH-1:0];
            if (w_ctrl_wr) r_irq_en <= wbs_dat_i[1];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_cycles  <= '0;
            r_done    <= 1'b0;
            r_pending <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_irq <= r_pending & r_irq_en;
            if (w_start) begin
                r_a       <= r_opa;
                r_b       <= r_opb;
                r_cycles  <= '0;
                r_done    <= 1'b0;
                r_pending <= 1'b0;
            end else if (r_state == CALC) begin
                if (r_cycles != 32'hFFFF_FFFF) r_cycles <= r_cycles + 32'd1;
                if (r_b == '0) begin
                    r_result  <= r_a;
                    r_done    <= 1'b1;
                    r_pending <= 1'b1;
                end else if (r_a < r_b) begin
                    r_a <= r_b;
                    r_b <= r_a;
                end else begin
                    r_a <= r_a - r_b;
                end
                // completion outranks a same-edge IRQ_CLR
                if (w_clr && r_b != '0) r_pending <= 1'b0;
            end else if (w_clr) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign irq_o     = r_irq;
    assign busy_o    = (r_state == CALC);
endmodule

// File: tb/tb_wb_gcd_unit.sv
`timescale 1ns/1ps
// Directed bench for wb_gcd_unit: register access, GCD runs, IRQ handling,
// reset abort, address miss and byte-lane writes.
module tb_wb_gcd_unit;
    localparam logic [31:0] B = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat_i = '0, adr = '0;
    logic        ack, irq, busy;
    logic [31:0] dat_o;

    int checks = 0;
    int errors = 0;
    int busy_total = 0;
    logic [31:0] rd;
    int b0;

    wb_gcd_unit #(.WIDTH(16), .BASE_ADDR(32'h3000_0000)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o), .irq_o(irq), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (busy) busy_total <= busy_total + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] q);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        @(posedge clk); #1;
        chk("ack_1cyc", {31'b0, ack}, 32'd1);
        q = dat_o;
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("ack_drop", {31'b0, ack}, 32'd0);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, B + off, d, 4'hF, q);
    endtask

    task automatic rdchk(input string tag, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] q;
        wb_xfer(1'b0, B + off, 32'h0, 4'hF, q);
        chk(tag, q, exp);
    endtask

    task automatic wait_done();
        logic [31:0] q;
        q = '0;
        for (int i = 0; i < 300; i++) begin
            wb_xfer(1'b0, B + 32'h0C, 32'h0, 4'hF, q);
            if (q[1]) break;
        end
        chk("done_timeout", {31'b0, q[1]}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b2,
                       input logic [31:0] res, input logic [31:0] cyc_n);
        int s;
        wr(32'h00, a);
        wr(32'h04, b2);
        s = busy_total;
        wr(32'h08, 32'h1);
        wait_done();
        chk({tag, "_busy"}, busy_total - s, cyc_n);
        rdchk({tag, "_res"}, 32'h10, res);
        rdchk({tag, "_cyc"}, 32'h14, cyc_n);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        for (int k = 0; k < 6; k++) rdchk("rst_reg", 32'(k * 4), 32'h0);

        // 48,18 with interrupt enabled
        wr(32'h00, 32'd48);
        wr(32'h04, 32'd18);
        b0 = busy_total;
        wr(32'h08, 32'h3);
        wait_done();
        chk("g48_busy", busy_total - b0, 32'd9);
        rdchk("g48_res", 32'h10, 32'd6);
        rdchk("g48_cyc", 32'h14, 32'd9);
        rdchk("g48_stat", 32'h0C, 32'h6);
        chk("g48_irq", {31'b0, irq}, 32'd1);
        wr(32'h08, 32'h6);
        chk("irq_clr", {31'b0, irq}, 32'd0);
        rdchk("stat_clr", 32'h0C, 32'h2);
        rdchk("ctrl_rd", 32'h08, 32'h2);

        run("g15", 32'd15, 32'd5, 32'd5, 32'd5);
        run("g0y", 32'd0, 32'd7, 32'd7, 32'd2);
        run("g00", 32'd0, 32'd0, 32'd0, 32'd1);
        run("gx0", 32'd9, 32'd0, 32'd9, 32'd1);

        // operand write and START while busy
        wr(32'h00, 32'd48);
        wr(32'h04, 32'd18);
        b0 = busy_total;
        wr(32'h08, 32'h1);
        wr(32'h00, 32'd99);
        wr(32'h08, 32'h1);
        wait_done();
        chk("wb_busy", busy_total - b0, 32'd9);
        rdchk("wb_res", 32'h10, 32'd6);
        rdchk("wb_opa", 32'h00, 32'd99);
        rdchk("wb_cyc", 32'h14, 32'd9);
        b0 = busy_total;
        wr(32'h08, 32'h1);
        wait_done();
        chk("g99_busy", busy_total - b0, 32'd10);
        rdchk("g99_res", 32'h10, 32'd9);
        rdchk("g99_cyc", 32'h14, 32'd10);

        // reset abort during a 1000-cycle run
        wr(32'h00, 32'd1000);
        wr(32'h04, 32'd1);
        wr(32'h08, 32'h3);
        repeat (5) @(posedge clk);
        chk("abort_pre", {31'b0, busy}, 32'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_irq", {31'b0, irq}, 32'd0);
        @(negedge clk) rst = 1'b0;
        b0 = busy_total;
        repeat (1100) @(posedge clk);
        #1;
        chk("abort_late", busy_total - b0, 32'd0);
        chk("abort_irq2", {31'b0, irq}, 32'd0);
        rdchk("abort_res", 32'h10, 32'd0);
        rdchk("abort_stat", 32'h0C, 32'h0);
        rdchk("unmapped", 32'h40, 32'h0);

        // address miss
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_1000; sel = 4'hF;
        b0 = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) b0++;
        end
        chk("miss_ack", 32'(b0), 32'd0);
        @(negedge clk) begin stb = 1'b0; cyc = 1'b0; end

        // byte-lane write
        wr(32'h00, 32'h1234);
        begin
            logic [31:0] q;
            wb_xfer(1'b1, B, 32'h0000_AB00, 4'h2, q);
        end
        rdchk("byte_opa", 32'h00, 32'hAB34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/wb_gcd_unit.md
Name: wb_gcd_unit

Overview:
Wishbone-B4 classic slave peripheral that sits inside user_project_wrapper, directly on the management SoC Wishbone port. It holds operand, control, status and result registers. An iterative subtractive-Euclid engine computes GCD(A,B). Completion is reported through a sticky status bit, a maskable interrupt and a busy flag exported to the logic analyzer.

Parameters:
WIDTH, 16, operand/result width in bits (2..32)
BASE_ADDR, 32'h3000_0000, base of the 4 KB register window; only bits [31:12] are compared

Ports:
wb_clk_i  input  1  single clock; all logic on its rising edge
wb_rst_i  input  1  reset, synchronous, active-high
wbs_stb_i  input  1  Wishbone strobe
wbs_cyc_i  input  1  Wishbone cycle
wbs_we_i  input  1  1=write, 0=read
wbs_sel_i  input  4  byte enables
wbs_dat_i  input  32  write data
wbs_adr_i  input  32  byte address
wbs_ack_o  output  1  transfer acknowledge
wbs_dat_o  output  32  read data, valid while ack=1
irq_o  output  1  completion interrupt, level (to user_irq[0])
busy_o  output  1  engine busy (to la_data_out)

Behaviour:
- Reset (wb_rst_i=1 at a clock edge): all outputs 0; OPA/OPB/RESULT/CYCLES=0; irq_en=0; done=0; pending=0; FSM=IDLE. Applies mid-computation: the computation is abandoned and no result or IRQ is produced.
- Address hit: wbs_adr_i[31:12]==BASE_ADDR[31:12]. Register offset = wbs_adr_i[11:0]. Bits [1:0] are ignored.
- Handshake, 1 wait-state:
  - On an edge with stb&cyc&hit&!ack: ack<=1 for exactly one cycle, write committed at that edge, read data registered into wbs_dat_o.
  - At the next edge ack<=0, and wbs_dat_o<=0 at that same edge.
  - Back-to-back requests are therefore acked every other cycle.
  - No ack on a miss.
- Register map (unmapped offsets in the window: ack, read 0, writes dropped):
  - 0x00 OPA RW: bits [WIDTH-1:0]; upper bits read 0. Byte writes honour wbs_sel_i.
  - 0x04 OPB RW: same rules as OPA.
  - 0x08 CTRL:
    - bit0 START: write-1 pulse, reads 0.
    - bit1 IRQ_EN: RW.
    - bit2 IRQ_CLR: write-1 clears pending, reads 0.
    - Written only when sel[0]=1.
  - 0x0C STATUS RO: bit0 busy, bit1 done, bit2 pending.
  - 0x10 RESULT RO: zero-extended.
  - 0x14 CYCLES RO: 32-bit count of CALC cycles of the last run; saturates at 32'hFFFF_FFFF.
- FSM states IDLE, CALC.
  - IDLE + START write: internal a<=OPA, b<=OPB, CYCLES<=0, done<=0, pending<=0; enter CALC at the next edge.
  - CALC, each cycle CYCLES+=1, then:
    - b==0: RESULT<=a, done<=1, pending<=1, go to IDLE.
    - else if a<b: swap a,b.
    - else: a<=a-b (unsigned; no underflow is possible).
  - START while in CALC: ignored, no state change.
  - OPA/OPB writes while busy: update the registers only; the running computation uses its latched copies.
- Zero rules: GCD(0,0)=0 (CYCLES=1); GCD(x,0)=x (CYCLES=1); GCD(0,y)=y (CYCLES=2).
- Outputs:
  - busy_o = (state==CALC); STATUS.busy reads 1 from the edge after the START ack.
  - irq_o = pending & irq_en, registered.
  - Simultaneous completion and IRQ_CLR write in the same edge: set wins, pending=1.
  - done is sticky until the next START.

Test Plan:
- Reset, then read each offset 0x00–0x14: ack exactly 1 cycle after stb; all data 0; irq_o=0; busy_o=0.
- OPA=48, OPB=18, CTRL=0x3 -> busy for 9 cycles; RESULT=6; CYCLES=9; STATUS=0x6; irq_o=1; CTRL=0x6 (IRQ_CLR with IRQ_EN kept) -> irq_o=0; STATUS=0x2.
- OPA=15, OPB=5 -> RESULT=5, CYCLES=5. OPA=0, OPB=7 -> RESULT=7, CYCLES=2. OPA=0, OPB=0 -> RESULT=0, CYCLES=1.
- During busy: write OPA=99 and CTRL=0x1 -> current run still gives 6; OPA reads 99; CYCLES=9. A second START after done -> GCD(99,18)=9.
- Assert wb_rst_i mid-CALC -> next cycle busy_o=0; RESULT=0; irq_o=0; no late completion.
- Access 0x3000_1000 (miss) -> no ack in 8 cycles. Byte write sel=0x2, data 0x0000AB00 to OPA=0x1234 -> OPA reads 0xAB34.
